// File: rtl/softusb_txser_pkg.sv
// Shared types and constants for the SoftUSB bit-level transmitter.
package softusb_txser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_SE0,
        ST_EOPJ
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [2:0] STUFF_LIMIT = 3'd6;
    localparam int         FS_DIV_DEF  = 4;
    localparam int         LS_DIV_DEF  = 32;

    // {txp, txm} for the J state; low speed swaps the polarity.
    function automatic logic [1:0] line_j(input logic ls);
        return ls ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/softusb_txser_if.sv
// Byte handshake between the SIE register block and the transmitter.
interface softusb_txser_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/softusb_txser_txbit.sv
// Bit divider plus NRZI level and bit-stuff tracking.
module softusb_txser_txbit
    import softusb_txser_pkg::*;
#(
    parameter int FS_DIV = FS_DIV_DEF,
    parameter int LS_DIV = LS_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic low_speed,
    input  logic run,
    input  logic bit_valid,
    input  logic bit_in,
    output logic strobe,
    output logic near,
    output logic stuff,
    output logic stuff_due,
    output logic ls,
    output logic ls_n,
    output logic k_n
);

    logic [4:0] cnt;
    logic [4:0] div_m1;
    logic [2:0] ones;
    logic [2:0] ones_b;
    logic [2:0] ones_n;
    logic       k;
    logic       k_b;
    logic       stuff_n;

    assign div_m1    = ls ? 5'(LS_DIV - 1) : 5'(FS_DIV - 1);
    assign strobe    = run && (cnt == div_m1);
    assign near      = (cnt == div_m1 - 5'd1);
    assign stuff_due = !stuff && (ones == STUFF_LIMIT);

    // A stuff bit preempts whatever data bit the caller offers.
    always_comb begin
        ones_b  = start ? 3'd0 : ones;
        k_b     = start ? 1'b0 : k;
        ls_n    = start ? low_speed : ls;
        ones_n  = ones_b;
        k_n     = k_b;
        stuff_n = start ? 1'b0 : stuff;
        if (bit_valid) begin
            if (!start && stuff_due) begin
                stuff_n = 1'b1;
                k_n     = ~k_b;
                ones_n  = 3'd0;
            end else begin
                stuff_n = 1'b0;
                if (bit_in) begin
                    ones_n = ones_b + 3'd1;
                end else begin
                    k_n    = ~k_b;
                    ones_n = 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ones  <= '0;
            k     <= 1'b0;
            stuff <= 1'b0;
            ls    <= 1'b0;
        end else begin
            if (start)
                cnt <= '0;
            else if (run)
                cnt <= strobe ? 5'd0 : cnt + 5'd1;
            ones  <= ones_n;
            k     <= k_n;
            stuff <= stuff_n;
            ls    <= ls_n;
        end
    end

endmodule

// File: rtl/softusb_txser.sv
// USB FS/LS transmitter: SYNC, NRZI with bit stuffing, EOP.
module softusb_txser
    import softusb_txser_pkg::*;
#(
    parameter int FS_DIV = FS_DIV_DEF,
    parameter int LS_DIV = LS_DIV_DEF
) (
    input  logic             usb_clk,
    input  logic             usb_rst,
    input  logic             low_speed,
    softusb_txser_if.slave   bus,
    input  logic             eop_req,
    output logic             busy,
    output logic             txoe,
    output logic             txp,
    output logic             txm
);

    state_t     state, state_n;
    logic [7:0] sr, sr_n;
    logic [2:0] bidx, bidx_n;
    logic       last, last_n;
    logic       start, bit_valid, bit_in, nxt, take;
    logic       strobe, near, stuff, stuff_due;
    logic       ls, ls_n, k_n;
    logic       oe_n, rdy_n;
    logic [1:0] line_n;

    softusb_txser_txbit #(
        .FS_DIV(FS_DIV),
        .LS_DIV(LS_DIV)
    ) u_txbit (
        .clk      (usb_clk),
        .rst      (usb_rst),
        .start    (start),
        .low_speed(low_speed),
        .run      (state != ST_IDLE),
        .bit_valid(bit_valid),
        .bit_in   (bit_in),
        .strobe   (strobe),
        .near     (near),
        .stuff    (stuff),
        .stuff_due(stuff_due),
        .ls       (ls),
        .ls_n     (ls_n),
        .k_n      (k_n)
    );

    assign take = bus.tx_valid && bus.tx_ready;

    always_ff @(posedge usb_clk) begin
        if (usb_rst) begin
            state        <= ST_IDLE;
            sr           <= '0;
            bidx         <= '0;
            last         <= 1'b0;
            txoe         <= 1'b0;
            busy         <= 1'b0;
            bus.tx_ready <= 1'b0;
            txp          <= 1'b1;
            txm          <= 1'b0;
        end else begin
            state        <= state_n;
            sr           <= sr_n;
            bidx         <= bidx_n;
            last         <= last_n;
            txoe         <= oe_n;
            busy         <= oe_n;
            bus.tx_ready <= rdy_n;
            txp          <= line_n[1];
            txm          <= line_n[0];
        end
    end

    // sr[0] is always the next data bit once the current one is on the line.
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        bidx_n    = bidx;
        last_n    = last;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        nxt       = sr[0];
        unique case (state)
            ST_IDLE: begin
                if (bus.tx_valid) begin
                    state_n   = ST_DATA;
                    start     = 1'b1;
                    sr_n      = SYNC_BYTE;
                    bidx_n    = '0;
                    last_n    = 1'b0;
                    bit_valid = 1'b1;
                    bit_in    = SYNC_BYTE[0];
                end else if (eop_req) begin
                    state_n = ST_SE0;
                    start   = 1'b1;
                    bidx_n  = '0;
                end
            end
            ST_DATA: begin
                if (strobe) begin
                    if (!stuff) begin
                        if (bidx == 3'd7) begin
                            if (take) begin
                                sr_n   = bus.tx_data;
                                bidx_n = '0;
                                nxt    = bus.tx_data[0];
                            end else begin
                                last_n = 1'b1;
                            end
                        end else begin
                            sr_n   = sr >> 1;
                            bidx_n = bidx + 3'd1;
                            nxt    = sr[1];
                        end
                    end
                    if (stuff_due) begin
                        bit_valid = 1'b1;
                    end else if (last_n) begin
                        state_n = ST_SE0;
                        bidx_n  = '0;
                    end else begin
                        bit_valid = 1'b1;
                        bit_in    = nxt;
                    end
                end
            end
            ST_SE0: begin
                if (strobe) begin
                    if (bidx == 3'd1) begin
                        state_n = ST_EOPJ;
                        bidx_n  = '0;
                    end else begin
                        bidx_n = 3'd1;
                    end
                end
            end
            ST_EOPJ: begin
                if (strobe)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        oe_n  = (state_n != ST_IDLE);
        rdy_n = (state == ST_DATA) && !stuff && (bidx == 3'd7)
                && near && bus.tx_valid;
        unique case (state_n)
            ST_IDLE: line_n = line_j(low_speed);
            ST_DATA: line_n = k_n ? ~line_j(ls_n) : line_j(ls_n);
            ST_SE0:  line_n = 2'b00;
            ST_EOPJ: line_n = line_j(ls);
            default: line_n = line_j(low_speed);
        endcase
    end

endmodule

// File: tb/tb_softusb_txser.sv
// Directed bench for softusb_txser with hand-derived line traces.
module tb_softusb_txser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic low_speed = 1'b0;
    logic eop_req = 1'b0;
    logic busy, txoe, txp, txm;

    softusb_txser_if bus();

    softusb_txser dut (
        .usb_clk  (clk),
        .usb_rst  (rst),
        .low_speed(low_speed),
        .bus      (bus),
        .eop_req  (eop_req),
        .busy     (busy),
        .txoe     (txoe),
        .txp      (txp),
        .txm      (txm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0] ln [0:1023];
    int         rdy_at [0:7];
    int         ncyc, noe, nrdy, nb, x;
    bit         busy_ok, oe1;
    logic [7:0] bq [0:3];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [7:0] b2);
        bq[0] = b0;
        bq[1] = b1;
        bq[2] = b2;
        nb = n;
        bus.tx_data = b0;
        bus.tx_valid = 1'b1;
    endtask

    // Record the line from cycle 1 until txoe drops (or the budget ends).
    task automatic run(input int maxc, input int eop2_at, input int rst_at);
        int bi;
        bit ackp;
        bit nack;
        bi = 0;
        ackp = 0;
        nrdy = 0;
        noe = 0;
        busy_ok = 1;
        ncyc = 0;
        oe1 = 0;
        for (int i = 0; i < 8; i++) rdy_at[i] = -1;
        for (int c = 1; c <= maxc; c++) begin
            step();
            eop_req = (c == eop2_at);
            rst = (c == rst_at);
            ln[c] = {txp, txm};
            if (c == 1) oe1 = (txoe === 1'b1);
            if (busy !== txoe) busy_ok = 0;
            if (txoe === 1'b1) noe++;
            nack = (bus.tx_ready === 1'b1) && bus.tx_valid;
            if (bus.tx_ready === 1'b1 && nrdy < 8) begin
                rdy_at[nrdy] = c;
                nrdy++;
            end
            if (ackp) begin
                bi++;
                if (bi < nb) bus.tx_data = bq[bi];
                else bus.tx_valid = 1'b0;
            end
            ackp = nack;
            ncyc = c;
            if (txoe !== 1'b1) break;
        end
    endtask

    task automatic chk_line(input string tag, input string pat,
                            input int div);
        int bad;
        logic [1:0] j;
        logic [1:0] e;
        bad = 0;
        j = low_speed ? 2'b01 : 2'b10;
        for (int c = 1; c <= pat.len() * div; c++) begin
            case (pat[(c - 1) / div])
                "K":     e = ~j;
                "S":     e = 2'b00;
                default: e = j;
            endcase
            if (c > ncyc || ln[c] !== e) bad++;
        end
        chk(tag, 32'(bad), 0);
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        rst = 1'b1;
        step();
        step();
        chk("rst_oe", 32'(txoe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdy", 32'(bus.tx_ready), 0);
        chk("rst_line", 32'({txp, txm}), 32'h2);
        rst = 1'b0;
        step();
        chk("idle_oe", 32'(txoe), 0);

        // Full speed, one byte 0xA5
        send(1, 8'hA5, 8'h00, 8'h00);
        run(200, 0, 0);
        chk("a5_oe1", 32'(oe1), 1);
        chk("a5_nrdy", 32'(nrdy), 1);
        chk("a5_rdy_at", 32'(rdy_at[0]), 32);
        chk_line("a5_line", "KJKJKJKKKJJKJJKKSSJ", 4);
        chk("a5_noe", 32'(noe), 76);
        chk("a5_busy", 32'(busy_ok), 1);
        chk("a5_end", 32'(txoe), 0);

        // Full speed, 0xFF with a stuffed bit
        send(1, 8'hFF, 8'h00, 8'h00);
        run(200, 0, 0);
        chk("ff_rdy_at", 32'(rdy_at[0]), 32);
        chk_line("ff_line", "KJKJKJKKKKKKKJJJJSSJ", 4);
        chk("ff_noe", 32'(noe), 80);
        chk("ff_busy", 32'(busy_ok), 1);

        // Low speed, 0x00
        low_speed = 1'b1;
        step();
        chk("ls_idle_j", 32'({txp, txm}), 32'h1);
        send(1, 8'h00, 8'h00, 8'h00);
        run(1000, 0, 0);
        chk("ls_rdy_at", 32'(rdy_at[0]), 256);
        chk_line("ls_line", "KJKJKJKKJKJKJKJKSSJ", 32);
        chk("ls_noe", 32'(noe), 608);
        chk("ls_end_j", 32'({txp, txm}), 32'h1);

        // Low speed standalone EOP, second request while busy
        eop_req = 1'b1;
        run(300, 40, 0);
        chk("eop_oe1", 32'(oe1), 1);
        chk_line("eop_line", "SSJ", 32);
        chk("eop_noe", 32'(noe), 96);
        chk("eop_nrdy", 32'(nrdy), 0);
        x = 0;
        repeat (40) begin
            step();
            if (txoe !== 1'b0) x++;
        end
        chk("eop_no_extra", 32'(x), 0);

        // Full speed, three bytes back to back
        low_speed = 1'b0;
        step();
        send(3, 8'h01, 8'h02, 8'h03);
        run(300, 0, 0);
        chk("b3_nrdy", 32'(nrdy), 3);
        chk("b3_rdy0", 32'(rdy_at[0]), 32);
        chk("b3_rdy1", 32'(rdy_at[1]), 64);
        chk("b3_rdy2", 32'(rdy_at[2]), 96);
        chk_line("b3_line",
                 "KJKJKJKKKJKJKJKJKKJKJKJKKKJKJKJKSSJ", 4);
        chk("b3_noe", 32'(noe), 140);

        // Reset in the middle of a 2-byte packet
        send(2, 8'h11, 8'h22, 8'h00);
        run(300, 0, 40);
        bus.tx_valid = 1'b0;
        chk("mr_ncyc", 32'(ncyc), 41);
        chk("mr_nrdy", 32'(nrdy), 1);
        chk("mr_oe", 32'(txoe), 0);
        chk("mr_busy", 32'(busy), 0);
        x = 0;
        repeat (40) begin
            step();
            if (txoe !== 1'b0 || bus.tx_ready !== 1'b0) x++;
        end
        chk("mr_quiet", 32'(x), 0);
        send(1, 8'h00, 8'h00, 8'h00);
        run(200, 0, 0);
        chk_line("mr_line", "KJKJKJKKJKJKJKJKSSJ", 4);
        chk("mr_noe", 32'(noe), 76);
        chk("mr_rdy_at", 32'(rdy_at[0]), 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
